piso_serializer: RTL

Parameterised parallel-in/serial-out transmitter with a valid/ready load handshake, a generated serial clock and a one-word hold buffer for gap-free back-to-back frames. It serialises words of SIZE bits, MSB- or LSB-first, at a rate divided down from the system clock. It sits between the motion-control logic and the stepper driver serial interface, and replaces free-running shift registers that need an externally gated clock.

---
 rtl/piso_serializer.sv | 108 ++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in serial-out transmitter with generated sclk and one-word hold buffer
module piso_serializer #(
   parameter int SIZE        = 8,
   parameter int HALF_PERIOD = 2,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic            clk_in,
   input  logic            reset_in,
   input  logic [SIZE-1:0] data_in,
   input  logic            valid_in,
   output logic            ready_out,
   output logic            serial_out,
   output logic            sclk_out,
   output logic            busy_out,
   output logic            frame_done_out
);
   localparam int BW = $clog2(SIZE);
   localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [BW-1:0] BIT_LAST  = BW'(SIZE - 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          r_state;
   logic [SIZE-1:0] r_shift;
   logic [SIZE-1:0] r_hold;
   logic            r_hold_full;
   logic [BW-1:0]   r_bit;
   logic [HW-1:0]   r_half;
   logic            r_sclk;
   logic            r_serial;
   logic            r_busy;
   logic            r_ready;
   logic            r_done;

   logic            w_accept;
   logic            w_half_end;
   logic            w_frame_end;
   logic            w_first;
   logic [SIZE-1:0] w_load;
   logic [SIZE-1:0] w_shifted;

   assign w_accept    = valid_in && r_ready;
   assign w_load      = r_hold_full ? r_hold : data_in;
   assign w_first     = MSB_FIRST ? w_load[SIZE-1] : w_load[0];
   assign w_shifted   = MSB_FIRST ? {r_shift[SIZE-2:0], 1'b0} : {1'b0, r_shift[SIZE-1:1]};
   assign w_half_end  = (r_half == HALF_LAST);
   assign w_frame_end = (r_state == SHIFT) && w_half_end && r_sclk && (r_bit == BIT_LAST);

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_bit       <= '0;
         r_half      <= '0;
         r_sclk      <= 1'b0;
         r_serial    <= 1'b0;
         r_busy      <= 1'b0;
         r_ready     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done  <= w_frame_end;
         r_ready <= ~r_hold_full;
         if (w_accept && (r_state == SHIFT) && !w_frame_end) begin
            r_hold      <= data_in;
            r_hold_full <= 1'b1;
            r_ready     <= 1'b0;
         end
         // a fresh start and a gap-free reload at frame end share one load path
         if (((r_state == IDLE) && w_accept) || (w_frame_end && (r_hold_full || w_accept))) begin
            r_state     <= SHIFT;
            r_shift     <= w_load;
            r_serial    <= w_first;
            r_sclk      <= 1'b0;
            r_bit       <= '0;
            r_half      <= '0;
            r_busy      <= 1'b1;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
         end else if (w_frame_end) begin
            r_state  <= IDLE;
            r_serial <= 1'b0;
            r_sclk   <= 1'b0;
            r_busy   <= 1'b0;
            r_bit    <= '0;
            r_half   <= '0;
         end else if (r_state == SHIFT) begin
            r_half <= w_half_end ? '0 : r_half + 1'b1;
            if (w_half_end) begin
               r_sclk <= ~r_sclk;
               if (r_sclk) begin
                  r_bit    <= r_bit + 1'b1;
                  r_shift  <= w_shifted;
                  r_serial <= MSB_FIRST ? w_shifted[SIZE-1] : w_shifted[0];
               end
            end
         end
      end
   end

   assign ready_out      = r_ready;
   assign serial_out     = r_serial;
   assign sclk_out       = r_sclk;
   assign busy_out       = r_busy;
   assign frame_done_out = r_done;
endmodule
